// File: rtl/bootrom_read_port.sv
// Boot ROM read port: 2-cycle pipelined ROM reads with a 3-entry in-order response FIFO.
// Optional macro BOOTROM_READ_PORT_ALIGN_CHECK_EN flags misaligned requests as errors.
module bootrom_read_port #(
    parameter int ADDR_W = 13,
    parameter int SRC_W  = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [SRC_W-1:0]  req_source,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_data,
    output logic [SRC_W-1:0]  resp_source,
    output logic              resp_error,
    output logic              rom_me,
    output logic              rom_oe,
    output logic [10:0]       rom_addr,
    input  logic [31:0]       rom_q
);

    logic              accept;
    logic              req_err;
    logic              push;
    logic              pop;

    logic              if_valid;
    logic [SRC_W-1:0]  if_src;
    logic              if_err;

    logic [31:0]       f_data [3];
    logic [SRC_W-1:0]  f_src  [3];
    logic              f_err  [3];
    logic [1:0]        wr_ptr;
    logic [1:0]        rd_ptr;
    logic [1:0]        count;

`ifdef BOOTROM_READ_PORT_ALIGN_CHECK_EN
    assign req_err = (req_addr[1:0] != 2'b00);
`else
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^req_addr[1:0];
    assign req_err         = 1'b0;
`endif

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // The in-flight slot counts against capacity so a push can never overflow the FIFO.
    assign req_ready = !reset && (({1'b0, count} + {2'b00, if_valid}) < 3'd3);
    assign accept    = req_valid && req_ready;
    assign rom_me    = accept && !req_err;
    assign rom_addr  = reset ? '0 : 11'(req_addr[ADDR_W-1:2]);
    assign rom_oe    = if_valid && !if_err;

    assign push = if_valid;
    assign pop  = resp_valid && resp_ready;

    assign resp_valid  = (count != 2'd0);
    assign resp_data   = resp_valid ? f_data[rd_ptr] : '0;
    assign resp_source = resp_valid ? f_src[rd_ptr]  : '0;
    assign resp_error  = resp_valid ? f_err[rd_ptr]  : 1'b0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            if_valid <= 1'b0;
            if_src   <= '0;
            if_err   <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            for (int unsigned i = 0; i < 3; i++) begin
                f_data[i] <= '0;
                f_src[i]  <= '0;
                f_err[i]  <= 1'b0;
            end
        end else begin
            if_valid <= accept;
            if (accept) begin
                if_src <= req_source;
                if_err <= req_err;
            end
            if (push) begin
                f_data[wr_ptr] <= if_err ? '0 : rom_q;
                f_src[wr_ptr]  <= if_src;
                f_err[wr_ptr]  <= if_err;
                wr_ptr         <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule
